// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the L1 cache to physical-memory arbiter.
package cache_arb_types;

  localparam int DEFAULT_LINE_WIDTH = 256;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ICACHE,
    ARB_DCACHE
  } arb_state_t;

  typedef enum logic {
    ARB_OP_READ,
    ARB_OP_WRITE
  } arb_op_t;

endpackage

// File: rtl/cache_arbiter.sv
// Serialises I-cache fills and D-cache fills/writebacks onto one memory port.
// Define CACHE_ARB_RR_EN for round-robin on contention instead of fixed D-cache priority.
module cache_arbiter #(
  parameter int LINE_WIDTH = cache_arb_types::DEFAULT_LINE_WIDTH,
  parameter int ADDR_WIDTH = cache_arb_types::DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,

  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  import cache_arb_types::*;

  arb_state_t            state;
  arb_op_t               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic d_req;
  logic i_req;
  logic grant_d;
  logic grant_i;

`ifdef CACHE_ARB_RR_EN
  logic last_grant;  // 0 = I-cache served last, 1 = D-cache served last
`endif

  assign d_req = dcache_pmem_read | dcache_pmem_write;
  assign i_req = icache_pmem_read;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_req && i_req) begin
`ifdef CACHE_ARB_RR_EN
      grant_d = ~last_grant;
      grant_i = last_grant;
`else
      grant_d = 1'b1;
`endif
    end else begin
      grant_d = d_req;
      grant_i = i_req;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      op_q    <= ARB_OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef CACHE_ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            state   <= ARB_DCACHE;
            // A simultaneous read and write from the D-cache resolves to the writeback.
            op_q    <= dcache_pmem_write ? ARB_OP_WRITE : ARB_OP_READ;
            addr_q  <= dcache_pmem_address;
            wdata_q <= dcache_pmem_wdata;
`ifdef CACHE_ARB_RR_EN
            last_grant <= 1'b1;
`endif
          end else if (grant_i) begin
            state   <= ARB_ICACHE;
            op_q    <= ARB_OP_READ;
            addr_q  <= icache_pmem_address;
            wdata_q <= '0;
`ifdef CACHE_ARB_RR_EN
            last_grant <= 1'b0;
`endif
          end
        end
        ARB_ICACHE, ARB_DCACHE: begin
          if (pmem_resp) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Memory side is driven purely from the latched request, so client glitches never reach it.
  assign pmem_read    = (state != ARB_IDLE) && (op_q == ARB_OP_READ);
  assign pmem_write   = (state != ARB_IDLE) && (op_q == ARB_OP_WRITE);
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign icache_pmem_resp  = (state == ARB_ICACHE) && pmem_resp;
  assign dcache_pmem_resp  = (state == ARB_DCACHE) && pmem_resp;
  assign icache_pmem_rdata = (state == ARB_ICACHE) ? pmem_rdata : '0;
  assign dcache_pmem_rdata = (state == ARB_DCACHE) ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level ownership model.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
`ifdef CACHE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          icache_pmem_read = 1'b0;
  logic [AW-1:0] icache_pmem_address = '0;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic          dcache_pmem_read = 1'b0;
  logic          dcache_pmem_write = 1'b0;
  logic [AW-1:0] dcache_pmem_address = '0;
  logic [LW-1:0] dcache_pmem_wdata = '0;
  logic [LW-1:0] dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  cache_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: who owns memory (0 none, 1 I-cache, 2 D-cache) and the request it was granted.
  int            m_owner = 0;
  int            m_last  = 1;
  logic          m_write = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [LW-1:0] m_wdata = '0;

  int txn_cnt     = 0;
  bit prev_strobe = 1'b0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int pick;
    if (rst) begin
      m_owner = 0; m_last = 1; m_write = 1'b0; m_addr = '0; m_wdata = '0;
    end else if (m_owner != 0) begin
      if (pmem_resp) m_owner = 0;
    end else begin
      pick = 0;
      if ((dcache_pmem_read || dcache_pmem_write) && icache_pmem_read)
        pick = (RR && m_last == 2) ? 1 : 2;
      else if (dcache_pmem_read || dcache_pmem_write) pick = 2;
      else if (icache_pmem_read) pick = 1;
      if (pick == 2) begin
        m_owner = 2; m_last = 2; m_write = dcache_pmem_write;
        m_addr = dcache_pmem_address; m_wdata = dcache_pmem_wdata;
      end else if (pick == 1) begin
        m_owner = 1; m_last = 1; m_write = 1'b0;
        m_addr = icache_pmem_address; m_wdata = '0;
      end
    end
  endtask

  // Sample mid-cycle and compare every output against the model.
  task automatic settle();
    logic e_rd, e_wr, e_ir, e_dr;
    @(negedge clk);
    e_rd = (m_owner != 0) && !m_write;
    e_wr = (m_owner != 0) && m_write;
    e_ir = (m_owner == 1) && pmem_resp;
    e_dr = (m_owner == 2) && pmem_resp;
    check("m_pmem_read",  LW'(pmem_read),  LW'(e_rd));
    check("m_pmem_write", LW'(pmem_write), LW'(e_wr));
    check("m_i_resp",     LW'(icache_pmem_resp), LW'(e_ir));
    check("m_d_resp",     LW'(dcache_pmem_resp), LW'(e_dr));
    if (e_rd || e_wr) check("m_pmem_address", LW'(pmem_address), LW'(m_addr));
    if (e_wr) check("m_pmem_wdata", pmem_wdata, m_wdata);
    if (e_ir) check("m_i_rdata", icache_pmem_rdata, pmem_rdata);
    if (e_dr) check("m_d_rdata", dcache_pmem_rdata, pmem_rdata);
    if ((pmem_read || pmem_write) && !prev_strobe) txn_cnt++;
    prev_strobe = pmem_read || pmem_write;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] line_a5, line_dead;
    int order [4];
    int waited;
    line_a5   = {8{32'hA5A5_A5A5}};
    line_dead = {8{32'hDEAD_BEEF}};

    // Reset with a non-zero memory bus to show outputs are all zero regardless.
    rst = 1'b1;
    pmem_rdata = {8{$urandom()}};
    advance(); advance();
    rst = 1'b0;
    settle();
    check("rst_pmem_read",  LW'(pmem_read), '0);
    check("rst_pmem_write", LW'(pmem_write), '0);
    check("rst_address",    LW'(pmem_address), '0);
    check("rst_wdata",      pmem_wdata, '0);
    check("rst_i_rdata",    icache_pmem_rdata, '0);
    check("rst_d_rdata",    dcache_pmem_rdata, '0);
    advance();

    // I-cache fill at 0x1240; request dropped after grant, memory answers after 5 strobe cycles.
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_1240;
    settle();
    check("t1_no_strobe_yet", LW'(pmem_read), '0);
    advance();
    icache_pmem_read = 1'b0; icache_pmem_address = 32'h0000_0000;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("t1_read",    LW'(pmem_read), LW'(1'b1));
      check("t1_address", LW'(pmem_address), LW'(32'h0000_1240));
      check("t1_i_resp_low", LW'(icache_pmem_resp), '0);
      advance();
    end
    pmem_resp = 1'b1; pmem_rdata = line_a5;
    settle();
    check("t1_i_resp",  LW'(icache_pmem_resp), LW'(1'b1));
    check("t1_i_rdata", icache_pmem_rdata, line_a5);
    check("t1_d_resp",  LW'(dcache_pmem_resp), '0);
    advance();
    pmem_resp = 1'b0;
    settle(); advance();

    // Simultaneous I read 0x100 and D write 0x200: D first, idle gap, then I.
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h100;
    dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h200; dcache_pmem_wdata = line_dead;
    txn_cnt = 0;
    settle(); advance();
    dcache_pmem_write = 1'b0;
    settle();
    check("t2_d_write", LW'(pmem_write), LW'(1'b1));
    check("t2_d_noread", LW'(pmem_read), '0);
    check("t2_d_addr",  LW'(pmem_address), LW'(32'h200));
    check("t2_d_wdata", pmem_wdata, line_dead);
    advance();
    pmem_resp = 1'b1;
    settle();
    check("t2_d_resp", LW'(dcache_pmem_resp), LW'(1'b1));
    check("t2_i_held", LW'(icache_pmem_resp), '0);
    advance();
    pmem_resp = 1'b0;
    settle();
    check("t2_gap", LW'(pmem_read | pmem_write), '0);
    advance();
    icache_pmem_read = 1'b0;
    settle();
    check("t2_i_read", LW'(pmem_read), LW'(1'b1));
    check("t2_i_addr", LW'(pmem_address), LW'(32'h100));
    advance();
    pmem_resp = 1'b1; pmem_rdata = {8{$urandom()}};
    settle();
    check("t2_i_resp", LW'(icache_pmem_resp), LW'(1'b1));
    advance();
    pmem_resp = 1'b0;
    settle(); advance();
    check("t2_txn_count", LW'(txn_cnt), LW'(2));

    // D-cache moves its address after grant; memory side must hold 0x200.
    dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h200; dcache_pmem_wdata = {8{$urandom()}};
    settle(); advance();
    dcache_pmem_address = 32'h300; dcache_pmem_wdata = '0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("t3_addr_held", LW'(pmem_address), LW'(32'h200));
      advance();
    end
    pmem_resp = 1'b1; dcache_pmem_write = 1'b0;
    settle();
    check("t3_addr_at_resp", LW'(pmem_address), LW'(32'h200));
    check("t3_d_resp", LW'(dcache_pmem_resp), LW'(1'b1));
    advance();
    pmem_resp = 1'b0;
    settle(); advance();

    // Reset in the middle of a D-cache read abandons it.
    dcache_pmem_read = 1'b1; dcache_pmem_address = 32'h400;
    settle(); advance();
    dcache_pmem_read = 1'b0;
    settle();
    check("t4_read_active", LW'(pmem_read), LW'(1'b1));
    rst = 1'b1;
    advance();
    rst = 1'b0; pmem_resp = 1'b1;
    settle();
    check("t4_strobes_dropped", LW'(pmem_read | pmem_write), '0);
    check("t4_no_d_resp", LW'(dcache_pmem_resp), '0);
    advance();

    // pmem_resp while idle produces no client response.
    settle();
    check("t5_idle_i_resp", LW'(icache_pmem_resp), '0);
    check("t5_idle_d_resp", LW'(dcache_pmem_resp), '0);
    advance();
    pmem_resp = 1'b0;
    settle(); advance();

    // Continuous contention for four transactions.
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h500;
    dcache_pmem_read = 1'b1; dcache_pmem_address = 32'h600;
    for (int t = 0; t < 4; t++) begin
      waited = 0;
      settle();
      while (!(pmem_read || pmem_write) && waited < 4) begin
        advance(); settle(); waited++;
      end
      check("t6_grant_wait", LW'(waited < 4), LW'(1'b1));
      order[t] = (pmem_address == 32'h600) ? 2 : 1;
      advance();
      pmem_resp = 1'b1; pmem_rdata = {8{$urandom()}};
      settle(); advance();
      pmem_resp = 1'b0;
    end
    for (int t = 0; t < 4; t++)
      check($sformatf("t6_order_%0d", t), LW'(order[t]), LW'((RR && (t % 2 == 1)) ? 1 : 2));
    icache_pmem_read = 1'b0; dcache_pmem_read = 1'b0;
    settle(); advance();

    // Random traffic, including rare resets and stray responses.
    for (int c = 0; c < 400; c++) begin
      rst                 = ($urandom_range(63) == 0);
      icache_pmem_read    = ($urandom_range(2) == 0);
      icache_pmem_address = $urandom();
      dcache_pmem_read    = ($urandom_range(3) == 0);
      dcache_pmem_write   = ($urandom_range(3) == 0);
      dcache_pmem_address = $urandom();
      dcache_pmem_wdata   = {$urandom(), $urandom(), $urandom(), $urandom(),
                             $urandom(), $urandom(), $urandom(), $urandom()};
      pmem_resp           = ($urandom_range(2) == 0);
      pmem_rdata          = {$urandom(), $urandom(), $urandom(), $urandom(),
                             $urandom(), $urandom(), $urandom(), $urandom()};
      settle(); advance();
    end
    rst = 1'b0; icache_pmem_read = 1'b0; dcache_pmem_read = 1'b0;
    dcache_pmem_write = 1'b0; pmem_resp = 1'b0;
    settle(); advance();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Sits directly downstream of the pipelined core's split L1 caches. The instruction cache serves the core's inst_* port; the data cache serves its data_* port.
- Merges the two caches' line-fill and writeback requests onto the single shared physical-memory port (cacheline adaptor / main memory).
- Serialises requests with a registered-grant FSM and latches the winning request. The memory side is therefore stable for the whole transaction, even if a client misbehaves.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- ADDR_WIDTH, 32, physical line address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- icache_pmem_read  in  1  I-cache line-fill request.
- icache_pmem_address  in  ADDR_WIDTH  I-cache line address.
- icache_pmem_rdata  out  LINE_WIDTH  fill data to I-cache.
- icache_pmem_resp  out  1  I-cache transaction complete.
- dcache_pmem_read  in  1  D-cache line-fill request.
- dcache_pmem_write  in  1  D-cache writeback request.
- dcache_pmem_address  in  ADDR_WIDTH  D-cache line address.
- dcache_pmem_wdata  in  LINE_WIDTH  writeback data.
- dcache_pmem_rdata  out  LINE_WIDTH  fill data to D-cache.
- dcache_pmem_resp  out  1  D-cache transaction complete.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_WIDTH  memory address.
- pmem_wdata  out  LINE_WIDTH  memory write data.
- pmem_rdata  in  LINE_WIDTH  memory read data.
- pmem_resp  in  1  memory transaction complete.

Behaviour:
- States: ARB_IDLE, ARB_ICACHE, ARB_DCACHE.
- Reset (sync, rst=1 at posedge):
  - state=ARB_IDLE; latched op/address/wdata cleared to 0.
  - All outputs 0.
  - Reset during ARB_ICACHE/ARB_DCACHE abandons the transaction; pmem strobes drop the cycle after the reset edge.
- ARB_IDLE:
  - pmem_read=pmem_write=0; both client resps 0.
  - At the posedge, if any request is pending, latch op, address and wdata from the winner and enter the matching serve state.
  - Fixed priority: D-cache over I-cache.
  - No request: stay in ARB_IDLE.
- Serve states:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are driven from the latched registers only.
  - Exactly one strobe is high.
  - Held constant until pmem_resp.
- Completion:
  - In the cycle pmem_resp=1, the granted client's resp=1 combinationally.
  - Its rdata = pmem_rdata, passed through in the same cycle.
  - Next state is ARB_IDLE.
- The non-granted client always sees resp=0. Its rdata is the last value driven (don't-care).
- Latency: request seen at edge N → pmem strobe valid cycle N+1 → client resp in the same cycle as pmem_resp.
  - Mandatory one ARB_IDLE cycle between back-to-back transactions.
- A client dropping its request mid-transaction is ignored. The transaction completes, and resp is still pulsed for one cycle.
- dcache_pmem_read and dcache_pmem_write both high: write wins; the read must be re-requested.
- pmem_resp while in ARB_IDLE is ignored; no client resp is generated.
- Both clients requesting while in a serve state: the waiting request is evaluated at the next ARB_IDLE cycle.

Optional Feature:
- Macro CACHE_ARB_RR_EN.
- Defined:
  - A 1-bit last_grant register (reset 0 = I-cache).
  - When both clients request in ARB_IDLE, grant goes to the client not served last.
  - last_grant updates on each grant.
  - A lone requester is always granted.
- Undefined: fixed D-cache priority as above; no extra state.

Decomposition:
- Package cache_arb_types:
  - arb_state_t enum (ARB_IDLE, ARB_ICACHE, ARB_DCACHE).
  - arb_op_t enum (ARB_OP_READ, ARB_OP_WRITE).
  - LINE_WIDTH/ADDR_WIDTH default constants.
- No sub-module: FSM plus latch registers fit one module. Priority selection is an always_comb block inside it.

Test Plan:
- I-cache read only, addr 0x0000_1240; memory responds 5 cycles later with data 0xA5…A5 → pmem_read=1 with pmem_address=0x0000_1240 from the cycle after the request; icache_pmem_resp=1 with rdata=0xA5…A5 in the pmem_resp cycle; dcache_pmem_resp stays 0.
- Both request in the same cycle: I read 0x100, D write 0x200 with wdata 0xDEAD… → D serviced first (pmem_write, 0x200); ARB_IDLE gap of one cycle; then I read 0x100. Total of exactly two pmem transactions.
- The D-cache changes its address to 0x300 mid-transaction, after grant at 0x200 → pmem_address stays 0x200 until resp.
- rst asserted during ARB_DCACHE → next cycle: pmem_read=pmem_write=0, state ARB_IDLE, no resp pulse.
- pmem_resp pulsed while idle → no client resp.
- With CACHE_ARB_RR_EN: both clients request continuously for 4 transactions → grant order D, I, D, I. Without the macro → D, D, D, D while the D-cache keeps requesting.
